// File: rtl/div_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Captures an N-bit unsigned value on start and holds the packed BCD result on bcd.
module div_bcd_converter #(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + N;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   sreg;
  logic [SW-1:0]   sreg_step;
  logic [BW-1:0]   adj;
  logic [CW-1:0]   cnt;
  logic            load;
  logic            last;

  // Add 3 to every BCD nibble >= 5 so the following left shift carries correctly.
  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    adj = sreg[SW-1:N];
    for (int d = 0; d < DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
  end

  assign sreg_step = {adj[BW-2:0], sreg[N-1:0], 1'b0};
  assign load      = start && ((state == IDLE) || (state == DONE));
  assign last      = (state == SHIFT) && (cnt == CW'(1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      bcd  <= '0;
    end else if (load) begin
      sreg <= {{BW{1'b0}}, bin};
      cnt  <= CW'(N);
    end else if (state == SHIFT) begin
      sreg <= sreg_step;
      cnt  <= cnt - CW'(1);
      // bcd only ever sees the finished field, never a partial conversion.
      if (last) bcd <= sreg_step[SW-1:N];
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div_bcd_converter.sv
// Self-checking bench for div_bcd_converter: 8-bit/3-digit and 16-bit/5-digit instances,
// scoreboard queues popped on done, table-driven spot values plus multi-cycle corner sequences.
module tb_div_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  bin8;
  logic [15:0] bin16;
  logic        busy8, done8, busy16, done16;
  logic [11:0] bcd8;
  logic [19:0] bcd16;

  int vectors     = 0;
  int miscompares = 0;

  logic [11:0] q8[$];
  logic [19:0] q16[$];
  bit          prev8  = 1'b0;
  bit          prev16 = 1'b0;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  div_bcd_converter #(.N(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8)
  );

  div_bcd_converter #(.N(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digit extraction by division, packed into nibbles.
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (done8) begin
      check("done8_width", 32'(prev8), 0);
      if (q8.size() == 0) check("spurious_done8", 32'(done8), 0);
      else                check("bcd8", 32'(bcd8), 32'(q8.pop_front()));
    end
    prev8 = done8;
  end

  always @(posedge clk) begin
    #1;
    if (done16) begin
      check("done16_width", 32'(prev16), 0);
      if (q16.size() == 0) check("spurious_done16", 32'(done16), 0);
      else                 check("bcd16", 32'(bcd16), 32'(q16.pop_front()));
    end
    prev16 = done16;
  end

  task automatic run8(input logic [7:0] v, input logic [11:0] exp);
    int lat;
    q8.push_back(exp);
    bin8   = v;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    bin8   = ~v;
    check("busy8_after_accept", 32'(busy8), 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done8 && lat < 40);
    check("latency8", lat, 8);
  endtask

  task automatic run16(input logic [15:0] v, input logic [19:0] exp);
    int lat;
    q16.push_back(exp);
    bin16   = v;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    bin16   = ~v;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done16 && lat < 60);
    check("latency16", lat, 16);
  endtask

  initial begin
    tbl[0] = '{8'd0,   12'h000};
    tbl[1] = '{8'd255, 12'h255};
    tbl[2] = '{8'd99,  12'h099};
    tbl[3] = '{8'd100, 12'h100};
    tbl[4] = '{8'd205, 12'h205};
    tbl[5] = '{8'd9,   12'h009};
    tbl[6] = '{8'd10,  12'h010};
    tbl[7] = '{8'd199, 12'h199};
    tbl[8] = '{8'd128, 12'h128};

    rst = 1'b1; start8 = 1'b0; bin8 = '0; start16 = 1'b0; bin16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_bcd8",   32'(bcd8),  0);
    check("reset_busy8",  32'(busy8), 0);
    check("reset_done8",  32'(done8), 0);
    check("reset_bcd16",  32'(bcd16), 0);
    check("reset_busy16", 32'(busy16), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run8(tbl[i].bin, tbl[i].exp);

    for (int v = 0; v < 256; v++) run8(8'(v), 12'(to_bcd(v)));

    // Back-to-back: start held high, second value presented after the first accept.
    begin
      int t_done1, t_done2;
      t_done1 = -1; t_done2 = -1;
      repeat (3) @(posedge clk);
      #1;
      q8.push_back(12'h012);
      bin8 = 8'd12; start8 = 1'b1;
      @(posedge clk); #1;
      q8.push_back(12'h250);
      bin8 = 8'd250;
      for (int i = 1; i <= 17; i++) begin
        @(posedge clk); #1;
        if (i == 9) start8 = 1'b0;
        check("b2b_busy", 32'(busy8), (i == 8 || i == 17) ? 0 : 1);
        if (done8 && t_done1 < 0)      t_done1 = i;
        else if (done8 && t_done2 < 0) t_done2 = i;
      end
      check("b2b_done_spacing", t_done2 - t_done1, 9);
    end

    // Ignored start: a start pulse on the third busy cycle must not disturb the conversion.
    begin
      int lat;
      repeat (2) @(posedge clk);
      #1;
      q8.push_back(12'h037);
      bin8 = 8'd37; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
        if (lat == 2) begin start8 = 1'b1; bin8 = 8'd200; end
        if (lat == 3) start8 = 1'b0;
      end while (!done8 && lat < 40);
      check("ignored_start_latency", lat, 8);
      check("ignored_start_bcd", 32'(bcd8), 32'h037);
      for (int i = 0; i < 15; i++) begin
        @(posedge clk); #1;
        check("ignored_start_no_rerun", 32'(busy8), 0);
      end
    end

    // Reset on the 4th busy cycle, with start asserted alongside it.
    begin
      q8.push_back(12'h180);
      bin8 = 8'd180; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
        @(posedge clk); #1;
      end
      check("pre_reset_busy", 32'(busy8), 1);
      rst = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start8 = 1'b0;
      q8.delete();
      check("mid_reset_busy", 32'(busy8), 0);
      check("mid_reset_bcd",  32'(bcd8),  0);
      check("mid_reset_done", 32'(done8), 0);
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        check("post_reset_idle", 32'(busy8 | done8), 0);
      end
      run8(8'd180, 12'h180);
    end

    run16(16'd65535, 20'h65535);
    run16(16'd10000, 20'h10000);
    run16(16'd0,     20'h00000);
    for (int i = 0; i < 6; i++) begin
      int v;
      v = int'($urandom_range(0, 65535));
      run16(16'(v), 20'(to_bcd(v)));
    end

    repeat (3) @(posedge clk);
    #2;
    check("q8_drained",  q8.size(),  0);
    check("q16_drained", q16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_bcd_converter.md
# div_bcd_converter

Sequential binary-to-BCD converter sitting directly downstream of the divider: it captures the N-bit unsigned quotient (or remainder) the divider produces and converts it to packed BCD with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. Results go to the display/print path. A start/busy/done handshake lets the surrounding control logic sequence a new divide while the previous result is still held on `bcd`.

## Interface
- `N`, default 8: width of the binary input. Matches the divider's `N`.
- `DIGITS`, default 3: number of BCD digits. Must satisfy DIGITS ≥ ceil(N·log10 2). N=8 → 3; N=16 → 5.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request conversion of `bin`. Sampled on a rising edge.
- `bin` in N: unsigned value to convert. Sampled only on the edge that accepts `start`.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse marking `bcd` as newly valid.
- `bcd` out 4·DIGITS: packed BCD result, most-significant digit in the top nibble.

## Operation
- FSM has three states: IDLE, SHIFT and DONE.
- **IDLE → SHIFT** on `start`=1. On that edge:
  - load the shift register = {4·DIGITS zeros, `bin`};
  - load the bit counter = N.
- **SHIFT:** each edge performs one step:
  - every nibble of the BCD field that is ≥ 5 gets +3, combinationally;
  - the whole {bcd field, bin field} register then shifts left by 1;
  - the counter decrements.
- **SHIFT → DONE** on the edge where the counter goes 1→0. That same edge loads the `bcd` output register with the final BCD field.
- **DONE:**
  - if `start`=1, go to SHIFT and reload exactly as from IDLE (back-to-back accept);
  - otherwise go to IDLE.
- Accepting `start`:
  - `start` is accepted only in IDLE or DONE;
  - `start` while in SHIFT is ignored, with no effect on the conversion in progress and no queuing.
  - `bin` may change freely after the accepting edge.
- Output signals:
  - `busy` = (state == SHIFT);
  - `done` = (state == DONE).
- `bcd` holds the last completed result until the next completion. It never shows intermediate values.
- Width rules:
  - shift register is 4·DIGITS + N bits;
  - counter is ceil(log2(N+1)) bits;
  - each add-3 is a 4-bit add with no carry out. A nibble ≥ 5 plus 3 is ≤ 12, so it never overflows.
- No divide-by-zero handling here. Whatever N-bit value arrives is converted.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=0, shift register 0, counter 0.
- Latency, for `start` accepted on edge k:
  - `busy`=1 after edges k … k+N−1;
  - `done`=1 and the new `bcd` are valid after edge k+N, for exactly one cycle.
- Throughput: holding `start`=1 continuously gives one result every N+1 cycles.
- Reset mid-conversion: on the reset edge, return to IDLE, clear `bcd` to 0, and emit no `done`. A `start` asserted in the same cycle as `rst` is ignored.
- Input `bin`=0 still takes the full N cycles. There is no early termination.

## Test plan
- **Zero and max input (N=8, DIGITS=3).** After reset, check `bcd`=0, `busy`=0, `done`=0.
  - `start` with `bin`=0 → `done` pulses exactly 8 edges later, `bcd`=12'h000.
  - `bin`=255 → `bcd`=12'h255.
- **Sweep.** Convert every value 0..255, compared against a reference model of (v/100, v/10%10, v%10).
  - Spot checks: 99 → 12'h099, 100 → 12'h100, 205 → 12'h205.
  - `done` is exactly one cycle wide each time.
- **Ignored start.** Start `bin`=37, then pulse `start` with `bin`=200 on the 3rd busy cycle.
  - `bcd`=12'h037 when `done` pulses.
  - No second `done` follows.
- **Back-to-back.** Hold `start`=1, with `bin`=12 and then 250 presented on the successive accepting edges.
  - Results are 12'h012 then 12'h250.
  - The two `done` pulses are 9 cycles apart.
  - `busy` drops only during the DONE cycle.
- **Reset mid-operation.** Start `bin`=180 and assert `rst` on the 4th busy cycle.
  - Next cycle: `busy`=0, `bcd`=0.
  - No `done` ever appears.
  - A subsequent `start` with `bin`=180 gives 12'h180.
- **Wide configuration (N=16, DIGITS=5).**
  - `bin`=65535 → 20'h65535 after 16 cycles.
  - `bin`=10000 → 20'h10000.
